// File: rtl/sb_pkg.sv
// sb_pkg: shared switchboard stream constants and sizing helpers
package sb_pkg;
  localparam int SB_DEST_W = 32;
  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sb_fifo_mem.sv
// sb_fifo_mem: register array with one synchronous write port and one asynchronous read port
module sb_fifo_mem #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sb_stream_fifo.sv
// sb_stream_fifo: first-word-fall-through elastic buffer for a switchboard packet stream
module sb_stream_fifo
  import sb_pkg::*;
#(
  parameter int DW    = 256,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          in_data,
  input  logic [SB_DEST_W-1:0]   in_dest,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DW-1:0]          out_data,
  output logic [SB_DEST_W-1:0]   out_dest,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       pkt_count
);
  localparam int PTR_W = sb_ptr_w(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int MW    = DW + SB_DEST_W + 1;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_pkt_count;
  logic [MW-1:0]    w_rdata;
  logic             w_push, w_pop;
  // Handshakes depend only on registered state and rst, never on out_ready
  assign in_ready  = !rst && (r_count != CW'(DEPTH));
  assign out_valid = !rst && (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign {out_last, out_dest, out_data} = w_rdata;
  assign count     = r_count;
  assign pkt_count = r_pkt_count;
  sb_fifo_mem #(.W(MW), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({in_last, in_dest, in_data}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_count <= '0;
    end else begin
      r_wr_ptr    <= w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
      r_rd_ptr    <= w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
      r_count     <= (w_push && !w_pop) ? r_count + CW'(1) :
                     (w_pop && !w_push) ? r_count - CW'(1) : r_count;
      r_pkt_count <= (w_pop && out_last) ? r_pkt_count + CNT_W'(1) : r_pkt_count;
    end
  end
  always_ff @(posedge clk) assert (r_count <= CW'(DEPTH));
endmodule

// File: tb/tb_sb_stream_fifo.sv
// tb_sb_stream_fifo: directed scoreboard bench for sb_stream_fifo
module tb_sb_stream_fifo;
  localparam int DW = 256;
  typedef struct {
    logic [DW-1:0] d;
    logic [31:0]   dest;
    logic          last;
  } pkt_t;
  logic          clk = 0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [31:0]   in_dest;
  logic          in_last, in_valid, in_ready;
  logic [DW-1:0] out_data;
  logic [31:0]   out_dest;
  logic          out_last, out_valid, out_ready;
  logic [2:0]    count;
  logic [31:0]   pkt_count;
  int            n_chk = 0, n_err = 0, n_pop = 0, base;
  bit            acc;
  pkt_t          sb[$];
  pkt_t          e;

  sb_stream_fifo #(.DW(DW), .DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_dest(out_dest), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted pushes are queued, each pop is checked against the oldest entry
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        n_pop++;
        chk("sb_nonempty", DW'(sb.size() != 0), DW'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_dest", DW'(out_dest), DW'(e.dest));
          chk("sb_last", DW'(out_last), DW'(e.last));
        end
      end
      if (in_valid && in_ready) sb.push_back('{in_data, in_dest, in_last});
    end
  end

  initial begin
    rst = 1; in_data = '0; in_dest = '0; in_last = 0; in_valid = 0; out_ready = 0;
    repeat (3) begin
      cyc();
      chk("rst_in_ready", DW'(in_ready), DW'(0));
      chk("rst_out_valid", DW'(out_valid), DW'(0));
      chk("rst_count", DW'(count), DW'(0));
    end
    rst = 0; #1;
    chk("idle_in_ready", DW'(in_ready), DW'(1));
    chk("idle_pkt_count", DW'(pkt_count), DW'(0));

    in_data = {32{8'h01}}; in_dest = 5; in_last = 1; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    chk("pt_valid", DW'(out_valid), DW'(1));
    chk("pt_data", out_data, {32{8'h01}});
    chk("pt_dest", DW'(out_dest), DW'(5));
    chk("pt_last", DW'(out_last), DW'(1));
    cyc();
    chk("pt_count", DW'(count), DW'(0));
    chk("pt_pkt_count", DW'(pkt_count), DW'(1));
    chk("pt_empty", DW'(out_valid), DW'(0));

    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = DW'(i); in_dest = 32'(i + 10); in_last = i[0]; in_valid = 1;
      cyc();
      chk("fill_count", DW'(count), DW'(i < 4 ? i + 1 : 4));
      chk("fill_head", out_data, DW'(0));
      if (i >= 3) chk("fill_blocked", DW'(in_ready), DW'(0));
    end
    base = n_pop; out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      if (count == 0 && !in_valid) break;
      acc = in_valid && in_ready;
      cyc();
      if (acc) in_valid = 0;
    end
    chk("fill_drained", DW'(count), DW'(0));
    chk("fill_pops", DW'(n_pop - base), DW'(5));

    out_ready = 0; in_last = 0;
    for (int i = 0; i < 2; i++) begin
      in_data = DW'(100 + i); in_dest = 32'(i); in_valid = 1;
      cyc();
    end
    chk("ss_prefill", DW'(count), DW'(2));
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      in_data = DW'(102 + k); in_dest = 32'(k + 2);
      cyc();
      chk("ss_count", DW'(count), DW'(2));
      chk("ss_head", out_data, DW'(101 + k));
    end
    in_valid = 0;
    for (int k = 0; k < 10 && count != 0; k++) cyc();
    chk("ss_drained", DW'(count), DW'(0));

    out_ready = 0; in_data = DW'(12'hABC); in_dest = 7; in_last = 1; in_valid = 1;
    cyc();
    in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_data", out_data, DW'(12'hABC));
      chk("bp_dest", DW'(out_dest), DW'(7));
      chk("bp_last", DW'(out_last), DW'(1));
      chk("bp_count", DW'(count), DW'(1));
    end
    out_ready = 1;
    cyc();
    chk("bp_pkt_count", DW'(pkt_count), DW'(4));

    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(200 + i); in_dest = 32'(i); in_last = (i == 2); in_valid = 1;
      cyc();
    end
    in_valid = 0;
    chk("mr_count", DW'(count), DW'(3));
    rst = 1; #1;
    chk("mr_rst_ready", DW'(in_ready), DW'(0));
    chk("mr_rst_valid", DW'(out_valid), DW'(0));
    cyc();
    rst = 0;
    chk("mr_count0", DW'(count), DW'(0));
    chk("mr_valid0", DW'(out_valid), DW'(0));
    chk("mr_pkt0", DW'(pkt_count), DW'(0));
    in_data = '1; in_dest = 9; in_last = 1; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    chk("mr_out_data", out_data, {DW{1'b1}});
    chk("mr_out_last", DW'(out_last), DW'(1));
    chk("mr_out_count", DW'(count), DW'(1));
    cyc();
    chk("mr_alone", DW'(out_valid), DW'(0));
    chk("mr_pkt1", DW'(pkt_count), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
